wgt_load_ctrl: RTL
==================

Name: wgt_load_ctrl

Overview:
Loader/sequencer directly upstream of the 16-filter weight shift register-file bank. It reads BUFFER_SIZE weight words from the weight SRAM. Each word holds one weight per filter for one kernel position, so the bank is read vertically. It drives the bank's data, per-filter shift enables and select_wgt so that all filter RFs fill in parallel. It also sequences a recirculating "rotate" pass (select_wgt=0) that cycles the stored weights through the RFs for one full kernel.

Parameters:
DATA_WIDTH, 8, bits per weight
BUFFER_SIZE, 27, weights per filter RF (3x3x3 kernel)
BUFFER_COUNT, 16, number of filter RFs driven
ADDR_WIDTH, 10, weight SRAM word-address width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle pulse: begin LOAD from wgt_base_addr
rotate  input  1  single-cycle pulse: begin ROTATE pass
num_filter  input  5  active filters 1..16; 0 means 16; sampled at start/rotate
wgt_base_addr  input  ADDR_WIDTH  first SRAM word of the kernel set; sampled at start
wgt_mem_rd_en  output  1  SRAM read strobe
wgt_mem_addr  output  ADDR_WIDTH  SRAM read address
wgt_mem_data  input  BUFFER_COUNT*DATA_WIDTH  SRAM read data, valid 1 cycle after rd_en; filter i at [i*DATA_WIDTH +: DATA_WIDTH]
wgt_RF_shift_en  output  BUFFER_COUNT  per-filter shift enable to RF bank
data_out  output  BUFFER_COUNT*DATA_WIDTH  weight data to RF bank
select_wgt  output  1  1 = RFs take data_out, 0 = RFs recirculate
busy  output  1  operation in progress
done  output  1  single-cycle completion pulse

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge. All outputs go to 0, state goes to IDLE, counters clear. A reset mid-operation aborts it with no done pulse.
- All outputs are registered.
- States: IDLE, LOAD, ROTATE, DONE.
- IDLE:
  - start=1 latches base and mask, then goes to LOAD.
  - Else rotate=1 latches mask, then goes to ROTATE. start wins if both are asserted.
  - start/rotate in any other state are ignored.
- Mask: mask[i] = (i < N), where N = num_filter, or 16 if num_filter=0. Values above 16 saturate to 16.
- LOAD, start sampled at edge 0:
  - Cycles 1..BUFFER_SIZE: rd_en=1, addr = base+k for k=0..26, wrapping modulo 2^ADDR_WIDTH.
  - The SRAM returns data in cycles 2..28.
  - Data is registered into data_out and valid in cycles 3..29. In those cycles wgt_RF_shift_en=mask and select_wgt=1.
  - data_out lanes of masked-off filters are forced to 0.
  - Exactly BUFFER_SIZE shift cycles per enabled filter; word k reaches the RF as the k-th shift.
- ROTATE, rotate sampled at edge 0:
  - Cycles 1..BUFFER_SIZE: wgt_RF_shift_en=mask, select_wgt=0, data_out=0, rd_en=0.
- DONE: a single cycle with done=1, then IDLE.
  - After LOAD, done is in cycle 30.
  - After ROTATE, done is in cycle 28.
- busy=1 from the cycle after start/rotate through the last shift cycle (LOAD: cycles 1..29; ROTATE: cycles 1..27). busy=0 in the done cycle, so a new start may be issued in the done cycle.
- Outside shift cycles: wgt_RF_shift_en=0, select_wgt=0, data_out=0, rd_en=0.
- wgt_mem_addr holds its last value when rd_en=0 (reset value 0).
- Counters: read counter and shift counter are each $clog2(BUFFER_SIZE+1) bits and never exceed BUFFER_SIZE.

Test Plan:
- Basic load:
  - Stimulus: reset, num_filter=16, base=0x010. SRAM word at address a has lane i = (a + i) mod 256. Pulse start at cycle 0.
  - Required: rd_en in cycles 1..27 with addr 0x010..0x02A. shift_en=0xFFFF and select_wgt=1 in cycles 3..29; lane 5 in cycle 3 = 0x15. done only in cycle 30.
- Partial filters: num_filter=5 load.
  - Required: shift_en=0x001F during shift cycles; lanes 5..15 of data_out=0.
  - Repeat with num_filter=0: shift_en=0xFFFF.
- Address wrap: base=0x3F0 with ADDR_WIDTH=10.
  - Required: addr runs 0x3F0..0x3FF then 0x000..0x00A; 27 reads total.
- Rotate and collisions:
  - rotate with num_filter=3: shift_en=0x0007 and select_wgt=0 in cycles 1..27, rd_en never high, done in cycle 28.
  - start+rotate in the same IDLE cycle: LOAD runs.
  - start at cycle 10 of a LOAD: ignored, 27 reads only.
- Reset mid-load: drive rst_n=0 at cycle 12 of a LOAD.
  - Required: next cycle all outputs 0, no done pulse. A following start produces a full, correct 27-word load.
- Back-to-back: issue start in the done cycle of the previous LOAD.
  - Required: a new LOAD begins. Its rd_en asserts in the cycle after done.

Source files
------------

// File: rtl/wgt_load_if.sv
// wgt_load_if: command, weight-SRAM and RF-bank signals around the weight loader
interface wgt_load_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_COUNT = 16,
  parameter int ADDR_WIDTH   = 10
);
  logic start;
  logic rotate;
  logic [4:0] num_filter;
  logic [ADDR_WIDTH-1:0] wgt_base_addr;
  logic wgt_mem_rd_en;
  logic [ADDR_WIDTH-1:0] wgt_mem_addr;
  logic [BUFFER_COUNT*DATA_WIDTH-1:0] wgt_mem_data;
  logic [BUFFER_COUNT-1:0] wgt_RF_shift_en;
  logic [BUFFER_COUNT*DATA_WIDTH-1:0] data_out;
  logic select_wgt;
  logic busy;
  logic done;
  modport master (
    output start, rotate, num_filter, wgt_base_addr, wgt_mem_data,
    input  wgt_mem_rd_en, wgt_mem_addr, wgt_RF_shift_en, data_out, select_wgt, busy, done
  );
  modport slave (
    input  start, rotate, num_filter, wgt_base_addr, wgt_mem_data,
    output wgt_mem_rd_en, wgt_mem_addr, wgt_RF_shift_en, data_out, select_wgt, busy, done
  );
endinterface

// File: rtl/wgt_load_ctrl.sv
// wgt_load_ctrl: reads a kernel's weight words from SRAM and shifts them into all filter RFs in parallel
module wgt_load_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_SIZE  = 27,
  parameter int BUFFER_COUNT = 16,
  parameter int ADDR_WIDTH   = 10
) (
  input logic clk,
  input logic rst_n,
  wgt_load_if.slave bus
);
  localparam int CW = $clog2(BUFFER_SIZE + 1);
  localparam int W  = BUFFER_COUNT * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, ROTATE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] rd_cnt, rd_cnt_n, sh_cnt, sh_cnt_n;
  logic [ADDR_WIDTH-1:0] base, base_n, addr, addr_n;
  logic [BUFFER_COUNT-1:0] mask, mask_n, mask_in, shift, shift_n;
  logic [W-1:0] data, data_n, data_in;
  logic rd, rd_n, rd_d, sel, sel_n, busy, busy_n, done, done_n;
  always_comb begin
    for (int i = 0; i < BUFFER_COUNT; i++) begin
      mask_in[i] = bus.num_filter == '0 || i < int'(bus.num_filter);
      data_in[i*DATA_WIDTH +: DATA_WIDTH] = mask[i] ? bus.wgt_mem_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end
  // rd_d marks the cycle the SRAM presents the word requested one cycle earlier
  always_comb begin
    state_n = state;
    rd_cnt_n = rd_cnt;
    sh_cnt_n = sh_cnt;
    base_n = base;
    addr_n = addr;
    mask_n = mask;
    rd_n = 1'b0;
    shift_n = '0;
    data_n = '0;
    sel_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          state_n = LOAD;
          base_n = bus.wgt_base_addr;
          addr_n = bus.wgt_base_addr;
          mask_n = mask_in;
          rd_cnt_n = CW'(1);
          sh_cnt_n = '0;
          rd_n = 1'b1;
          busy_n = 1'b1;
        end else if (bus.rotate) begin
          state_n = ROTATE;
          mask_n = mask_in;
          sh_cnt_n = CW'(1);
          shift_n = mask_in;
          busy_n = 1'b1;
        end
      end
      LOAD: begin
        if (sh_cnt == CW'(BUFFER_SIZE)) begin
          state_n = DONE;
          done_n = 1'b1;
        end else begin
          busy_n = 1'b1;
          if (rd_cnt < CW'(BUFFER_SIZE)) begin
            rd_n = 1'b1;
            addr_n = base + ADDR_WIDTH'(rd_cnt);
            rd_cnt_n = rd_cnt + 1'b1;
          end
          if (rd_d) begin
            shift_n = mask;
            data_n = data_in;
            sel_n = 1'b1;
            sh_cnt_n = sh_cnt + 1'b1;
          end
        end
      end
      ROTATE: begin
        if (sh_cnt == CW'(BUFFER_SIZE)) begin
          state_n = DONE;
          done_n = 1'b1;
        end else begin
          busy_n = 1'b1;
          shift_n = mask;
          sh_cnt_n = sh_cnt + 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rd_cnt <= '0;
      sh_cnt <= '0;
      base <= '0;
      addr <= '0;
      mask <= '0;
      rd <= 1'b0;
      rd_d <= 1'b0;
      shift <= '0;
      data <= '0;
      sel <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      rd_cnt <= rd_cnt_n;
      sh_cnt <= sh_cnt_n;
      base <= base_n;
      addr <= addr_n;
      mask <= mask_n;
      rd <= rd_n;
      rd_d <= rd;
      shift <= shift_n;
      data <= data_n;
      sel <= sel_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
  assign bus.wgt_mem_rd_en = rd;
  assign bus.wgt_mem_addr = addr;
  assign bus.wgt_RF_shift_en = shift;
  assign bus.data_out = data;
  assign bus.select_wgt = sel;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
